// File: rtl/byte_data_memory.sv
// Byte-addressable data memory for the MIPS load/store stage: byte/half/word
// access with sign/zero extension, valid/ready handshake, post-reset clear sweep and sticky faults.
module byte_data_memory #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rdata,
    output logic        fault_misalign,
    output logic        fault_oob,
    output logic [31:0] fault_addr,
    input  logic        err_clr
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_READ_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            pulse_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic [31:0]     ld_data_q;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            misalign;
    logic            oob;
    logic            fault;
    logic            store_go;
    logic            load_go;
    logic            load_done;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     rd_word;
    logic [7:0]      sel_b;
    logic [15:0]     sel_h;
    logic [31:0]     ext;
    logic            any_set;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign idx       = addr[AW+1:2];
    assign lane      = addr[1:0];
    assign oob       = (addr[31:2] >= DEPTH_W);
    assign fault     = misalign | oob;
    assign store_go  = accept & req_we & ~fault;
    assign load_go   = accept & ~req_we & ~fault;
    assign load_done = (state_q == S_READ_WAIT) && (cnt_q == '0);
    assign any_set   = (fault_misalign | fault_oob) & ~err_clr;

    // A finished load is presented straight from the pending-load register so
    // READ_LAT = 1 responds in the cycle right after accept.
    assign rsp_valid = pulse_q | load_done;
    assign rsp_err   = load_done ? 1'b0 : err_q;
    assign rdata     = load_done ? ld_data_q : rdata_q;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = addr[0];
            2'd2:    misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (req_size)
            2'd0: begin
                be = 4'b0001 << lane;
                wd = {4{wdata[7:0]}};
            end
            2'd1: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        rd_word = mem[idx];
        sel_b   = rd_word[{lane, 3'b000} +: 8];
        sel_h   = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_size)
            2'd0:    ext = {{24{~req_unsigned & sel_b[7]}}, sel_b};
            2'd1:    ext = {{16{~req_unsigned & sel_h[15]}}, sel_h};
            default: ext = rd_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      if (&init_ptr_q) state_d = S_IDLE;
            S_IDLE:      if (load_go) state_d = S_READ_WAIT;
            S_READ_WAIT: if (cnt_q == '0) state_d = S_IDLE;
            default:     state_d = S_INIT;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            ld_data_q  <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= accept & (req_we | fault);
            if (state_q == S_INIT) init_ptr_q <= init_ptr_q + 1'b1;
            if (load_go) begin
                cnt_q     <= CW'(READ_LAT - 1);
                ld_data_q <= ext;
            end else if ((state_q == S_READ_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (accept && (req_we || fault)) begin
                err_q   <= fault;
                rdata_q <= '0;
            end else if (load_done) begin
                err_q   <= 1'b0;
                rdata_q <= ld_data_q;
            end
        end
    end

    // A fault accepted alongside err_clr wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_misalign <= 1'b0;
            fault_oob      <= 1'b0;
            fault_addr     <= '0;
        end else if (accept && fault) begin
            fault_misalign <= (fault_misalign & ~err_clr) | misalign;
            fault_oob      <= (fault_oob & ~err_clr) | oob;
            if (!any_set) fault_addr <= addr;
        end else if (err_clr) begin
            fault_misalign <= 1'b0;
            fault_oob      <= 1'b0;
            fault_addr     <= '0;
        end
    end

    // NOTE: the array has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[init_ptr_q] <= '0;
        end else if (store_go) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule
